// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolution path: tracked-branch entry layout
// and the resolve-unit state encoding.
package branch_resolve_unit_pkg;

   localparam int BRU_ADDR_W = 16;

   typedef struct packed {
      logic [BRU_ADDR_W-1:0] pc;
      logic                  taken;
      logic [BRU_ADDR_W-1:0] target;
   } branch_entry_t;

   typedef enum logic {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } bru_state_e;

   // Actual outcome disagrees with the prediction; a target is only
   // meaningful when the branch was actually taken.
   function automatic logic is_mispredict(input branch_entry_t entry,
                                          input logic res_taken,
                                          input logic [BRU_ADDR_W-1:0] res_target);
      return (res_taken != entry.taken) ||
             (res_taken && (res_target != entry.target));
   endfunction

endpackage

// File: rtl/branch_track_fifo.sv
// In-order tracking queue for outstanding predicted branches.
// Head data is read combinationally; clear empties the queue in one cycle.
module branch_track_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [PTR_W:0]   count;

   assign rdata = mem[head];
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= wdata;
      end
   end

   // Pointer and occupancy tracking; clear takes priority over push/pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            tail <= tail + PTR_ONE;
         end
         if (pop) begin
            head <= head + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: matches in-order resolutions against tracked
// predictions, emits the BTB/predictor update and, on a mispredict, a
// redirect + flush followed by a short hold-off window.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_RUN     | normal push/resolve handshaking
// ST_RECOVER | post-mispredict hold-off; both readies low, rec_cnt counts down
//
// The entry layout comes from the package, so ADDR_W must equal BRU_ADDR_W.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int ADDR_W         = BRU_ADDR_W,
   parameter int DEPTH          = 8,
   parameter int RECOVER_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pred_valid,
   output logic              pred_ready,
   input  logic [ADDR_W-1:0] pred_pc,
   input  logic              pred_taken,
   input  logic [ADDR_W-1:0] pred_target,
   input  logic              res_valid,
   output logic              res_ready,
   input  logic              res_taken,
   input  logic [ADDR_W-1:0] res_target,
   output logic              upd_valid,
   output logic [ADDR_W-1:0] upd_bia,
   output logic [ADDR_W-1:0] upd_bta,
   output logic              upd_taken,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              flush,
   output logic [15:0]       mispredict_count
);

   localparam int ENTRY_W = $bits(branch_entry_t);
   localparam int REC_W   = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;
   localparam logic [REC_W-1:0]  REC_LOAD = REC_W'(RECOVER_CYCLES);
   localparam logic [REC_W-1:0]  REC_ONE  = REC_W'(1);
   localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);

   bru_state_e       state;
   logic [REC_W-1:0] rec_cnt;

   branch_entry_t    push_entry;
   branch_entry_t    head_entry;
   logic [ENTRY_W-1:0] head_raw;
   logic             q_full;
   logic             q_empty;
   logic             pop_fire;
   logic             push_fire;
   logic             mispredict;

   assign pred_ready = !q_full  && (state == ST_RUN);
   assign res_ready  = !q_empty && (state == ST_RUN);

   assign pop_fire   = res_valid && res_ready;
   assign head_entry = branch_entry_t'(head_raw);
   assign mispredict = pop_fire && is_mispredict(head_entry, res_taken, res_target);
   // A mispredict squashes everything younger, including a same-cycle push.
   assign push_fire  = pred_valid && pred_ready && !mispredict;

   assign push_entry.pc     = pred_pc;
   assign push_entry.taken  = pred_taken;
   assign push_entry.target = pred_target;

   branch_track_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_track_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_fire),
      .pop   (pop_fire && !mispredict),
      .clear (mispredict),
      .wdata (push_entry),
      .rdata (head_raw),
      .full  (q_full),
      .empty (q_empty)
   );

   // Recovery FSM plus all registered update/redirect outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= ST_RUN;
         rec_cnt          <= '0;
         upd_valid        <= 1'b0;
         upd_bia          <= '0;
         upd_bta          <= '0;
         upd_taken        <= 1'b0;
         redirect_valid   <= 1'b0;
         redirect_pc      <= '0;
         flush            <= 1'b0;
         mispredict_count <= '0;
      end else begin
         upd_valid      <= pop_fire;
         redirect_valid <= mispredict;
         flush          <= mispredict;

         if (pop_fire) begin
            upd_bia   <= head_entry.pc;
            upd_bta   <= res_target;
            upd_taken <= res_taken;
         end

         if (mispredict) begin
            redirect_pc <= res_taken ? res_target : (head_entry.pc + PC_ONE);
            if (mispredict_count != 16'hFFFF) begin
               mispredict_count <= mispredict_count + 16'd1;
            end
         end

         case (state)
            ST_RUN: begin
               if (mispredict && (RECOVER_CYCLES > 0)) begin
                  state   <= ST_RECOVER;
                  rec_cnt <= REC_LOAD;
               end
            end
            ST_RECOVER: begin
               // Terminal count at 1: the final held-off cycle ends here.
               if (rec_cnt <= REC_ONE) begin
                  state   <= ST_RUN;
                  rec_cnt <= '0;
               end else begin
                  rec_cnt <= rec_cnt - REC_ONE;
               end
            end
            default: begin
               state   <= ST_RUN;
               rec_cnt <= '0;
            end
         endcase
      end
   end

endmodule
